// File: rtl/shift_pkg.sv
// Shared definitions for the serial-to-parallel receiver: mode encodings,
// FSM state enum and a small mode-decode helper.
package shift_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_SL   = 2'b01;
  localparam logic [1:0] MODE_SR   = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } state_e;

  // True for the two receiving modes; 00 and the reserved 11 both mean idle.
  function automatic logic is_rx_mode(input logic [1:0] mode);
    return (mode == MODE_SL) || (mode == MODE_SR);
  endfunction

endpackage

// File: rtl/shift_rx_obuf.sv
// Output word register with valid/ready handshake and sticky overrun flag.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         a word completed this cycle (word_i holds it)
//   word_i         completed word
//   clr_ovr_i      clear the sticky overrun flag (receiver returning to idle)
//   ready_i        consumer accept
//   parallel_o     held word
//   valid_o        parallel_o holds an unconsumed word
//   overrun_o      a completed word was dropped while the held word was stalled
module shift_rx_obuf #(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [BIT_WIDTH-1:0] word_i,
  input  logic                 clr_ovr_i,
  input  logic                 ready_i,
  output logic [BIT_WIDTH-1:0] parallel_o,
  output logic                 valid_o,
  output logic                 overrun_o
);

  logic [BIT_WIDTH-1:0] parallel_q, parallel_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  // Next-state for the held word, its valid flag and the overrun flag.
  always_comb begin
    parallel_d = parallel_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (load_i) begin
      // A held word that is being accepted this same edge frees the slot.
      if (!valid_q || ready_i) begin
        parallel_d = word_i;
        valid_d    = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (clr_ovr_i) begin
      overrun_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parallel_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      parallel_q <= parallel_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign parallel_o = parallel_q;
  assign valid_o    = valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/shift_rx.sv
// Serial-to-parallel receiver: shifts qualified serial bits MSB-first or
// LSB-first into a word and hands completed words to a double-buffered
// output register with a valid/ready handshake.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   en_i             receive enable (shifter and bit counter hold when low)
//   mode_i           00 idle/flush, 01 MSB-first, 10 LSB-first, 11 idle
//   serial_i         serial bit, used when en_i && serial_valid_i in RX
//   serial_valid_i   qualifies serial_i
//   parallel_o       last completed word
//   valid_o          parallel_o holds an unconsumed word
//   ready_i          consumer accept
//   overrun_o        sticky: a completed word was dropped
//   bit_count_o      bits collected in the current partial word
module shift_rx
  import shift_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic [1:0]                         mode_i,
  input  logic                               serial_i,
  input  logic                               serial_valid_i,
  output logic [BIT_WIDTH-1:0]               parallel_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               overrun_o,
  output logic [$clog2(BIT_WIDTH+1)-1:0]     bit_count_o
);

  localparam int unsigned CNT_W = $clog2(BIT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_WIDTH - 1);

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [BIT_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_WIDTH-1:0] shifted_c;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 word_done_c;
  logic                 clr_ovr_c;

  // Shifter contents after taking serial_i in the active direction.
  always_comb begin
    if (mode_q == MODE_SR) begin
      shifted_c = {serial_i, shift_q[BIT_WIDTH-1:1]};
    end else begin
      shifted_c = {shift_q[BIT_WIDTH-2:0], serial_i};
    end
  end

  // FSM next-state, shifter and bit counter.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    word_done_c = 1'b0;
    clr_ovr_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The entry cycle only latches the direction; no bit is taken.
        if (en_i && is_rx_mode(mode_i)) begin
          state_d = ST_RX;
          mode_d  = mode_i;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_RX: begin
        if (en_i) begin
          if (!is_rx_mode(mode_i)) begin
            state_d   = ST_IDLE;
            mode_d    = MODE_IDLE;
            shift_d   = '0;
            cnt_d     = '0;
            clr_ovr_c = 1'b1;
          end else if (mode_i != mode_q) begin
            // Direction flip: drop the partial word, skip this cycle's bit.
            mode_d  = mode_i;
            shift_d = '0;
            cnt_d   = '0;
          end else if (serial_valid_i) begin
            if (cnt_q == LAST_CNT) begin
              word_done_c = 1'b1;
              shift_d     = '0;
              cnt_d       = '0;
            end else begin
              shift_d = shifted_c;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_count_o = cnt_q;

  shift_rx_obuf #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_obuf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (word_done_c),
    .word_i     (shifted_c),
    .clr_ovr_i  (clr_ovr_c),
    .ready_i    (ready_i),
    .parallel_o (parallel_o),
    .valid_o    (valid_o),
    .overrun_o  (overrun_o)
  );

endmodule

// File: tb/tb_shift_rx.sv
// Bench for shift_rx: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a bit-list reference model.
module tb_shift_rx;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          ser;
  logic          sv;
  logic          rdy;
  logic [W-1:0]  parallel_o;
  logic          valid_o;
  logic          overrun_o;
  logic [CW-1:0] bit_count_o;

  shift_rx #(.BIT_WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .mode_i         (mode),
    .serial_i       (ser),
    .serial_valid_i (sv),
    .parallel_o     (parallel_o),
    .valid_o        (valid_o),
    .ready_i        (rdy),
    .overrun_o      (overrun_o),
    .bit_count_o    (bit_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: received bits kept as an ordered list.
  bit           m_rx;
  logic [1:0]   m_mode;
  bit           m_bits[$];
  logic [W-1:0] m_par;
  bit           m_valid;
  bit           m_ovr;

  task automatic model_reset();
    m_rx = 0; m_mode = 2'b00; m_bits.delete();
    m_par = '0; m_valid = 0; m_ovr = 0;
  endtask

  // First received bit is the MSB for mode 01, the LSB for mode 10.
  function automatic logic [W-1:0] build_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (m_mode == 2'b10) w[i] = m_bits[i];
      else                 w[W-1-i] = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_update();
    bit done = 0;
    bit leave = 0;
    bit acc;
    logic [W-1:0] word = '0;
    if (rst) begin
      model_reset();
      return;
    end
    acc = m_valid && rdy;
    if (!m_rx) begin
      if (en && (mode == 2'b01 || mode == 2'b10)) begin
        m_rx = 1; m_mode = mode; m_bits.delete();
      end
    end else if (en) begin
      if (mode == 2'b00 || mode == 2'b11) begin
        m_rx = 0; m_bits.delete(); leave = 1;
      end else if (mode != m_mode) begin
        m_mode = mode; m_bits.delete();
      end else if (sv) begin
        m_bits.push_back(ser);
        if (m_bits.size() == W) begin
          word = build_word(); done = 1; m_bits.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin m_par = word; m_valid = 1; end
      else m_ovr = 1;
    end else if (acc) begin
      m_valid = 0;
    end
    if (leave) m_ovr = 0;
  endtask

  task automatic check_all();
    chk_eq("parallel", 32'(parallel_o), 32'(m_par));
    chk_eq("valid", 32'(valid_o), 32'(m_valid));
    chk_eq("overrun", 32'(overrun_o), 32'(m_ovr));
    chk_eq("bit_count", 32'(bit_count_o), m_bits.size());
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(input bit e, input bit v, input bit s, input bit r, input logic [1:0] md);
    en = e; sv = v; ser = s; rdy = r; mode = md;
    step();
  endtask

  // Sends one word on consecutive cycles in the given mode's bit order.
  task automatic send_word(input logic [W-1:0] w, input logic [1:0] md, input bit r_body, input bit r_last);
    for (int i = 0; i < int'(W); i++) begin
      drive(1, 1, (md == 2'b10) ? w[i] : w[W-1-i], (i == int'(W) - 1) ? r_last : r_body, md);
    end
  endtask

  initial begin
    rst = 1; en = 0; sv = 0; ser = 0; rdy = 0; mode = 2'b00;
    model_reset();
    #1;
    check_all();
    step();
    rst = 0;
    drive(0, 0, 0, 0, 2'b00);

    // MSB-first
    drive(1, 1, 1, 1, 2'b01);
    chk_eq("entry_no_sample", 32'(bit_count_o), 0);
    send_word(8'hC0, 2'b01, 1, 1);
    chk_eq("sl_word", 32'(parallel_o), 32'hC0);
    chk_eq("sl_valid", 32'(valid_o), 1);
    drive(1, 0, 0, 1, 2'b01);
    chk_eq("sl_consumed", 32'(valid_o), 0);
    drive(1, 0, 0, 0, 2'b00);

    // LSB-first, same serial stream
    drive(1, 0, 0, 1, 2'b10);
    send_word(8'h03, 2'b10, 1, 1);
    chk_eq("sr_word", 32'(parallel_o), 32'h03);
    drive(1, 0, 0, 1, 2'b00);

    // Gaps in en_i / serial_valid_i
    drive(1, 0, 0, 1, 2'b01);
    for (int i = 0; i < int'(W); i++) begin
      logic [W-1:0] a5 = 8'hA5;
      while ($urandom_range(0, 2) == 0) begin
        bit ge = 1'($urandom_range(0, 1));
        drive(ge, ge ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 2'b01);
      end
      drive(1, 1, a5[W-1-i], 0, 2'b01);
    end
    chk_eq("gap_word", 32'(parallel_o), 32'hA5);

    // Backpressure and overrun
    drive(1, 0, 0, 1, 2'b01);
    send_word(8'h12, 2'b01, 0, 0);
    chk_eq("bp_first", 32'(parallel_o), 32'h12);
    send_word(8'h34, 2'b01, 0, 0);
    chk_eq("bp_kept", 32'(parallel_o), 32'h12);
    chk_eq("bp_overrun", 32'(overrun_o), 1);
    send_word(8'h34, 2'b01, 0, 1);
    chk_eq("bp_replace", 32'(parallel_o), 32'h34);
    chk_eq("bp_valid_stays", 32'(valid_o), 1);
    drive(1, 0, 0, 1, 2'b00);
    chk_eq("idle_clears_ovr", 32'(overrun_o), 0);

    // Abort via one idle cycle
    drive(1, 0, 0, 0, 2'b01);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 2'b01);
    drive(1, 0, 0, 0, 2'b00);
    drive(1, 0, 0, 0, 2'b01);
    send_word(8'h5A, 2'b01, 0, 0);
    chk_eq("abort_word", 32'(parallel_o), 32'h5A);

    // Direction flip mid-word discards the partial word
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 2'b01);
    drive(1, 1, 1, 1, 2'b10);
    chk_eq("flip_count", 32'(bit_count_o), 0);
    send_word(8'hC3, 2'b10, 0, 0);
    chk_eq("flip_word", 32'(parallel_o), 32'hC3);

    // Asynchronous reset mid-word with a word held
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 2'b10);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk_eq("arst_parallel", 32'(parallel_o), 0);
    chk_eq("arst_valid", 32'(valid_o), 0);
    chk_eq("arst_count", 32'(bit_count_o), 0);
    drive(1, 1, 1, 0, 2'b10);
    rst = 0;
    drive(1, 1, 1, 1, 2'b10);
    chk_eq("post_rst_entry", 32'(bit_count_o), 0);
    send_word(8'h96, 2'b10, 1, 1);
    chk_eq("post_rst_word", 32'(parallel_o), 32'h96);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] md = mode;
      if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 39) == 0) md = 2'b01;
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), md);
      rst = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
